sephirot_branch_issuer: RTL

SEPHIROT_BRANCH_ISSUER -- requirements
Module: sephirot_branch_issuer

---
 rtl/sephirot_branch_issuer_pkg.sv | 33 +++
 rtl/sephirot_branch_issuer_if.sv | 34 +++
 rtl/sephirot_lane_prio_enc.sv | 23 ++
 rtl/sephirot_branch_issuer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sephirot_branch_issuer_pkg.sv
// Shared sephirot definitions: branch-issuer FSM encoding, shadow default,
// PC-unit state constants and small arithmetic helpers.
package sephirot_branch_issuer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_SHADOW  = 2'd2,
    ST_STOPPED = 2'd3
  } issuer_state_e;

  // Cycles of lane results squashed after a redirect.
  localparam int SHADOW_DEFAULT = 2;
  localparam int TARGET_W       = 16;

  // PC-unit states, kept next to the issuer encoding so both sides agree.
  typedef enum logic [1:0] {
    PC_HALTED      = 2'd0,
    PC_FETCHING    = 2'd1,
    PC_REDIRECTING = 2'd2
  } pc_state_e;

  // Counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Relative jumps land one past the encoded offset (16-bit wrap).
  function automatic logic [15:0] rel_addr(input logic [15:0] off);
    return off + 16'd1;
  endfunction

endpackage

// File: rtl/sephirot_branch_issuer_if.sv
// Lane-result and PC-command bundle between the VLIW lanes, host and PC unit.
interface sephirot_branch_issuer_if
  import sephirot_branch_issuer_pkg::*;
#(
  parameter int NUM_LANES = 4
);
  logic                          enable;
  logic [NUM_LANES-1:0]          lane_valid;
  logic [NUM_LANES-1:0]          lane_branch;
  logic [NUM_LANES-1:0]          lane_abs;
  logic [NUM_LANES-1:0]          lane_exit;
  logic [TARGET_W*NUM_LANES-1:0] lane_target;
  logic                          resume_req;

  logic                          start;
  logic                          pc_add;
  logic                          pc_load;
  logic                          pc_stop;
  logic                          pc_resume;
  logic [TARGET_W-1:0]           pc_addr;
  logic                          stopped;
  logic                          proto_err;
  logic [15:0]                   redirect_cnt;

  modport master (
    output enable, lane_valid, lane_branch, lane_abs, lane_exit, lane_target, resume_req,
    input  start, pc_add, pc_load, pc_stop, pc_resume, pc_addr, stopped, proto_err, redirect_cnt
  );

  modport slave (
    input  enable, lane_valid, lane_branch, lane_abs, lane_exit, lane_target, resume_req,
    output start, pc_add, pc_load, pc_stop, pc_resume, pc_addr, stopped, proto_err, redirect_cnt
  );
endinterface

// File: rtl/sephirot_lane_prio_enc.sv
// Lowest-index-wins priority encoder: one-hot grant plus binary index.
module sephirot_lane_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Isolate the lowest set request bit, then fold it into an index.
  always_comb begin
    grant = req & (~req + {{(N-1){1'b0}}, 1'b1});
    idx   = {IDX_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx = idx | (grant[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
  end

  assign any = |req;

endmodule

// File: rtl/sephirot_branch_issuer.sv
// Turns per-lane branch/exit results into single-cycle PC-unit commands,
// squashing lane results for a shadow window after every redirect.
module sephirot_branch_issuer
  import sephirot_branch_issuer_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int SHADOW    = SHADOW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  sephirot_branch_issuer_if.slave  bus
);

  localparam int         IDX_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [2:0] SHADOW_LOAD = 3'(SHADOW);

  issuer_state_e        state_r, state_s;
  logic [2:0]           shadow_cnt_r, shadow_cnt_s;
  logic [NUM_LANES-1:0] req_s, grant_s;
  logic [IDX_W-1:0]     idx_s;
  logic                 any_s, win_exit_s, win_abs_s;
  logic [TARGET_W-1:0]  win_target_s;
  logic                 add_s, load_s, stop_s, resume_s, proto_s;
  logic                 add_r, load_r, stop_r, resume_r, proto_r, start_r, stopped_r;
  logic [TARGET_W-1:0]  pc_addr_s, pc_addr_r;
  logic [15:0]          redirect_s, redirect_r;

  assign req_s = bus.lane_valid & (bus.lane_branch | bus.lane_exit);

  sephirot_lane_prio_enc #(.N(NUM_LANES), .IDX_W(IDX_W)) u_prio (
    .req   (req_s),
    .grant (grant_s),
    .idx   (idx_s),
    .any   (any_s)
  );

  assign win_exit_s   = |(grant_s & bus.lane_exit);
  assign win_abs_s    = |(grant_s & bus.lane_abs);
  assign win_target_s = bus.lane_target[TARGET_W*idx_s +: TARGET_W];

  // Next-state and command decode; enable low overrides every state.
  always_comb begin
    state_s      = state_r;
    shadow_cnt_s = shadow_cnt_r;
    add_s        = 1'b0;
    load_s       = 1'b0;
    stop_s       = 1'b0;
    resume_s     = 1'b0;
    pc_addr_s    = pc_addr_r;
    proto_s      = proto_r | (bus.resume_req & (state_r != ST_STOPPED));
    if (!bus.enable) begin
      state_s      = ST_IDLE;
      shadow_cnt_s = 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_RUN;
        end
        ST_RUN: begin
          if (any_s) begin
            if (win_exit_s) begin
              stop_s  = 1'b1;
              state_s = ST_STOPPED;
            end else if (win_abs_s) begin
              load_s       = 1'b1;
              pc_addr_s    = win_target_s;
              shadow_cnt_s = SHADOW_LOAD;
              state_s      = ST_SHADOW;
            end else begin
              add_s        = 1'b1;
              pc_addr_s    = rel_addr(win_target_s);
              shadow_cnt_s = SHADOW_LOAD;
              state_s      = ST_SHADOW;
            end
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_SHADOW: begin
          if (shadow_cnt_r <= 3'd1) begin
            shadow_cnt_s = 3'd0;
            state_s      = ST_RUN;
          end else begin
            shadow_cnt_s = shadow_cnt_r - 3'd1;
          end
        end
        ST_STOPPED: begin
          if (bus.resume_req) begin
            resume_s     = 1'b1;
            shadow_cnt_s = SHADOW_LOAD;
            state_s      = ST_SHADOW;
          end else begin
            state_s = ST_STOPPED;
          end
        end
        default: begin
          state_s      = ST_IDLE;
          shadow_cnt_s = 3'd0;
        end
      endcase
    end
    redirect_s = (add_s | load_s) ? sat_inc16(redirect_r) : redirect_r;
  end

  // State, counters and registered outputs; reset wins over every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      shadow_cnt_r <= 3'd0;
      add_r        <= 1'b0;
      load_r       <= 1'b0;
      stop_r       <= 1'b0;
      resume_r     <= 1'b0;
      proto_r      <= 1'b0;
      start_r      <= 1'b0;
      stopped_r    <= 1'b0;
      pc_addr_r    <= 16'h0000;
      redirect_r   <= 16'h0000;
    end else begin
      state_r      <= state_s;
      shadow_cnt_r <= shadow_cnt_s;
      add_r        <= add_s;
      load_r       <= load_s;
      stop_r       <= stop_s;
      resume_r     <= resume_s;
      proto_r      <= proto_s;
      start_r      <= (state_s != ST_IDLE);
      stopped_r    <= (state_s == ST_STOPPED);
      pc_addr_r    <= pc_addr_s;
      redirect_r   <= redirect_s;
    end
  end

  assign bus.start        = start_r;
  assign bus.pc_add       = add_r;
  assign bus.pc_load      = load_r;
  assign bus.pc_stop      = stop_r;
  assign bus.pc_resume    = resume_r;
  assign bus.pc_addr      = pc_addr_r;
  assign bus.stopped      = stopped_r;
  assign bus.proto_err    = proto_r;
  assign bus.redirect_cnt = redirect_r;

endmodule
